uart_frame_scheduler: RTL and testbench

- Shares the single UART transmitter among NUM_REQ byte-message requesters: angle output, per-mic noise flags, debug sample bytes.
- Round-robin arbitrates, then sequences each granted byte out as a framed message: sync byte, source ID, payload.
- Sits between the producers and the UART interface.
- Drives the UART's data_rdy/data inputs and paces itself on tx_busy.

---
 rtl/uart_frame_scheduler_pkg.sv | 42 ++++
 rtl/uart_frame_scheduler_if.sv | 24 ++
 rtl/uart_frame_scheduler_rr_arbiter.sv | 38 +++
 rtl/uart_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_uart_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_scheduler_pkg.sv
// Shared types for the UART frame scheduler: FSM states, frame length and byte builder.
// UART_FRAME_CHECKSUM_EN appends an XOR checksum byte (ID ^ payload) to every frame.
package uart_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

  function automatic logic [7:0] frame_byte(
    input byte_idx_t  idx,
    input logic [7:0] sync,
    input logic [2:0] id,
    input logic [7:0] payload
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync;
      2'd1:    b = {5'b0, id};
`ifdef UART_FRAME_CHECKSUM_EN
      2'd3:    b = {5'b0, id} ^ payload;
`endif
      default: b = payload;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Requester and UART-side signals of the frame scheduler; master = scheduler, slave = environment.
// Requests are levels held until ack; the UART link is paced by tx_busy.
interface uart_frame_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    uart_data_rdy;
  logic [7:0]              uart_data;
  logic                    tx_busy;
  logic                    busy;
  logic [2:0]              active_id;

  modport master (
    input  req, req_data, tx_busy,
    output ack, uart_data_rdy, uart_data, busy, active_id
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, uart_data_rdy, uart_data, busy, active_id
  );
endinterface

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping modulo NUM_REQ.
// Zero latency; grants nothing while en is low.
module uart_frame_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      pos = sum[PW-1:0];
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Round-robin shares one UART among NUM_REQ requesters, sending SYNC/ID/payload frames (+checksum under UART_FRAME_CHECKSUM_EN).
// Grant to first uart_data_rdy is 1 cycle; each byte waits for tx_busy high (or BUSY_TIMEOUT) then low.
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         BUSY_TIMEOUT = 16
) (
  input logic                    clock,
  input logic                    reset,
  uart_frame_scheduler_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  byte_idx_t          idx_q, idx_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [7:0]         payload_q, payload_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic [2:0]         id_q, id_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               arb_en;

  assign arb_en = (state_q == S_IDLE) && !bus.tx_busy;

  uart_frame_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (bus.req),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    payload_d = payload_q;
    ack_d     = '0;
    rdy_d     = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    id_d      = id_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          ack_d     = gnt;
          payload_d = bus.req_data[gnt_idx];
          busy_d    = 1'b1;
          id_d      = 3'(gnt_idx);
          ptr_d     = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          idx_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        data_d  = frame_byte(idx_q, SYNC_BYTE, id_q, payload_q);
        rdy_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A UART that never raises tx_busy must not wedge the scheduler.
        if (bus.tx_busy || (tmo_q == TW'(BUSY_TIMEOUT - 1))) begin
          state_d = S_WAIT_LO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            id_d    = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      payload_q <= '0;
      ack_q     <= '0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
      ack_q     <= ack_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      id_q      <= id_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.uart_data_rdy = rdy_q;
  assign bus.uart_data     = data_q;
  assign bus.busy          = busy_q;
  assign bus.active_id     = id_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler: expected grant order and UART bytes queued at stimulus time.
// A simple UART model holds tx_busy high for 10 cycles after each data_rdy.
module tb_uart_frame_scheduler;
  localparam int NREQ = 4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_frame_scheduler_if #(.NUM_REQ(NREQ)) bus ();

  uart_frame_scheduler #(
    .NUM_REQ      (NREQ),
    .SYNC_BYTE    (8'hA5),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_bytes[$];
  int         exp_ids[$];
  int         busy_cnt = 0;
  bit         model_en = 1'b1;
  bit         hold_hi  = 1'b0;
  logic [3:0] hold     = '0;
  int         ack_cnt  = 0;
  int         rdy_cnt  = 0;
  int         busy_hi  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int id, input logic [7:0] d);
    logic [7:0] idb;
    idb = 8'(id);
    exp_ids.push_back(id);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(idb);
    exp_bytes.push_back(d);
`ifdef UART_FRAME_CHECKSUM_EN
    exp_bytes.push_back(idb ^ d);
`endif
  endtask

  // One cycle: observe outputs at the falling edge, then update requester and UART model inputs.
  task automatic step();
    int id;
    int eid;
    @(negedge clock);
    if (bus.busy) busy_hi++;
    if (bus.ack != '0) begin
      id = 0;
      for (int i = 0; i < NREQ; i++) if (bus.ack[i]) id = i;
      ack_cnt++;
      check("ack_onehot", 32'($countones(bus.ack)), 1);
      check("busy_at_ack", 32'(bus.busy), 1);
      if (exp_ids.size() == 0) begin
        check("extra_ack", 32'(id), 32'hFF);
      end else begin
        eid = exp_ids.pop_front();
        check("grant_order", 32'(id), 32'(eid));
        check("active_id_at_ack", 32'(bus.active_id), 32'(eid));
      end
      if (!hold[id]) bus.req[id] = 1'b0;
    end
    if (bus.uart_data_rdy) begin
      rdy_cnt++;
      if (exp_bytes.size() == 0) check("extra_byte", 32'(bus.uart_data), 32'h1FF);
      else check("uart_byte", 32'(bus.uart_data), 32'(exp_bytes.pop_front()));
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = hold_hi || (model_en && (busy_cnt > 0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit prev_busy;
    bit done;
    n = 0;
    done = 1'b0;
    prev_busy = bus.busy;
    while (!done && n < budget) begin
      step();
      n++;
      if (prev_busy && !bus.busy) check("busy_fall_after_tx_idle", 32'(bus.tx_busy), 0);
      prev_busy = bus.busy;
      done = (exp_bytes.size() == 0) && (exp_ids.size() == 0) && !bus.busy;
    end
    if (!done) check("frame_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    bus.req     = '0;
    hold        = '0;
    hold_hi     = 1'b0;
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    exp_bytes.delete();
    exp_ids.delete();
    repeat (3) step();
  endtask

  initial begin
    int a0;
    int r0;
    int n;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;

    // Reset state
    do_reset();
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rdy", 32'(bus.uart_data_rdy), 0);
    check("rst_data", 32'(bus.uart_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_active_id", 32'(bus.active_id), 0);
    reset = 1'b1;

    // Single request on requester 2
    a0 = ack_cnt; r0 = rdy_cnt;
    bus.req_data[2] = 8'h3C;
    push_frame(2, 8'h3C);
    bus.req = 4'b0100;
    wait_done(500);
    check("single_ack_count", 32'(ack_cnt - a0), 1);
    check("single_rdy_count", 32'(rdy_cnt - r0), FLEN);

    // All four requesters, then 0 and 1 again after the pointer wraps
    do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i] = 8'h10 + 8'(i);
      push_frame(i, 8'h10 + 8'(i));
    end
    bus.req = 4'b1111;
    wait_done(1500);
    push_frame(0, 8'h10);
    push_frame(1, 8'h11);
    bus.req = 4'b0011;
    wait_done(800);

    // Fairness between two continuously held requesters
    do_reset();
    reset = 1'b1;
    bus.req_data[0] = 8'h55;
    bus.req_data[3] = 8'h66;
    hold = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      push_frame(0, 8'h55);
      push_frame(3, 8'h66);
    end
    a0 = ack_cnt;
    bus.req = 4'b1001;
    n = 0;
    while ((ack_cnt - a0) < 6 && n < 2000) begin
      step();
      n++;
    end
    if ((ack_cnt - a0) < 6) check("fair_timeout", 32'(ack_cnt - a0), 6);
    bus.req = '0;
    hold = '0;
    wait_done(500);

    // UART never raises tx_busy: every byte rides the timeout
    do_reset();
    reset = 1'b1;
    model_en = 1'b0;
    r0 = rdy_cnt;
    bus.req_data[1] = 8'h77;
    push_frame(1, 8'h77);
    busy_hi = 0;
    bus.req = 4'b0010;
    wait_done(500);
    check("timeout_busy_cycles", 32'(busy_hi), 32'(FLEN * 18));
    check("timeout_rdy_count", 32'(rdy_cnt - r0), FLEN);

    // Reset while waiting for tx_busy on byte 1
    do_reset();
    reset = 1'b1;
    model_en = 1'b1;
    bus.req_data[0] = 8'h99;
    exp_ids.push_back(0);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h00);
    r0 = rdy_cnt;
    bus.req = 4'b0001;
    n = 0;
    while ((rdy_cnt - r0) < 2 && n < 300) begin
      step();
      n++;
    end
    if ((rdy_cnt - r0) < 2) check("midreset_timeout", 32'(rdy_cnt - r0), 2);
    reset = 1'b0;
    step();
    check("midrst_ack", 32'(bus.ack), 0);
    check("midrst_rdy", 32'(bus.uart_data_rdy), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_active_id", 32'(bus.active_id), 0);
    check("midrst_data", 32'(bus.uart_data), 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (60) step();
    check("midrst_no_more_bytes", 32'(rdy_cnt - r0), 2);
    bus.req_data[0] = 8'h21;
    bus.req_data[3] = 8'h24;
    push_frame(0, 8'h21);
    push_frame(3, 8'h24);
    bus.req = 4'b1001;
    wait_done(800);

    // tx_busy high at request time holds off the grant
    do_reset();
    reset = 1'b1;
    hold_hi = 1'b1;
    bus.tx_busy = 1'b1;
    bus.req_data[2] = 8'hC3;
    push_frame(2, 8'hC3);
    a0 = ack_cnt;
    bus.req = 4'b0100;
    repeat (20) step();
    check("no_ack_while_tx_busy", 32'(ack_cnt - a0), 0);
    hold_hi = 1'b0;
    bus.tx_busy = 1'b0;
    step();
    check("grant_on_tx_busy_fall", 32'(ack_cnt - a0), 1);
    wait_done(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
